// File: rtl/ysyx_22041207_muldiv_pkg.sv
// Shared definitions for the mul/div front-end controller: op codes,
// controller state encoding and the 32-bit result widening helper.
package ysyx_22041207_muldiv_pkg;

   localparam logic [2:0] OP_MUL  = 3'd0;
   localparam logic [2:0] OP_DIV  = 3'd1;
   localparam logic [2:0] OP_DIVU = 3'd2;
   localparam logic [2:0] OP_REM  = 3'd3;
   localparam logic [2:0] OP_REMU = 3'd4;

   // Most-negative values of the two operand widths, as seen after preparation.
   localparam logic [63:0] MIN_W = 64'hFFFF_FFFF_8000_0000;
   localparam logic [63:0] MIN_D = 64'h8000_0000_0000_0000;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_MUL_ISSUE = 3'd1,
      S_MUL_WAIT  = 3'd2,
      S_DIV_ISSUE = 3'd3,
      S_DIV_WAIT  = 3'd4,
      S_RESP      = 3'd5
   } state_t;

   // Word-mode results are always the sign-extended low 32 bits.
   function automatic logic [63:0] word_ext(input logic i_word, input logic [63:0] i_x);
      return i_word ? {{32{i_x[31]}}, i_x[31:0]} : i_x;
   endfunction

endpackage

// File: rtl/ysyx_22041207_muldiv_prep.sv
// Operand preparation and divider-free shortcut detection (pure combinational).
module ysyx_22041207_muldiv_prep
   import ysyx_22041207_muldiv_pkg::*;
(
   input  logic [2:0]  i_op,
   input  logic        i_word,
   input  logic [63:0] i_a,
   input  logic [63:0] i_b,
   output logic [63:0] o_a,
   output logic [63:0] o_b,
   output logic        o_sign,
   output logic        o_rem,
   output logic        o_is_mul,
   output logic        o_is_div,
   output logic        o_illegal,
   output logic        o_short,
   output logic [63:0] o_short_data
);

   logic        w_zero;
   logic        w_ovf;
   logic [63:0] w_min;

   assign o_is_mul  = (i_op == OP_MUL);
   assign o_is_div  = (i_op == OP_DIV) || (i_op == OP_DIVU) ||
                      (i_op == OP_REM) || (i_op == OP_REMU);
   assign o_illegal = !o_is_mul && !o_is_div;
   assign o_sign    = (i_op == OP_DIV) || (i_op == OP_REM);
   assign o_rem     = (i_op == OP_REM) || (i_op == OP_REMU);

   // Word mode: signed divides sign-extend, everything else zero-extends.
   always_comb begin
      o_a = i_a;
      o_b = i_b;
      if (i_word) begin
         if (o_sign) begin
            o_a = {{32{i_a[31]}}, i_a[31:0]};
            o_b = {{32{i_b[31]}}, i_b[31:0]};
         end else begin
            o_a = {32'd0, i_a[31:0]};
            o_b = {32'd0, i_b[31:0]};
         end
      end
   end

   // Divide-by-zero takes priority over signed overflow.
   assign w_min   = i_word ? MIN_W : MIN_D;
   assign w_zero  = (o_b == 64'd0);
   assign w_ovf   = o_sign && (o_a == w_min) && (&o_b);
   assign o_short = o_is_div && (w_zero || w_ovf);
   assign o_short_data = word_ext(i_word,
                                  w_zero ? (o_rem ? o_a : {64{1'b1}})
                                         : (o_rem ? 64'd0 : o_a));

endmodule

// File: rtl/ysyx_22041207_muldiv_ctrl.sv
// Mul/div front-end controller: accepts one request at a time, steers it to the
// multiplier or divider (or answers directly from shortcuts / a one-entry
// divider result cache) and returns a single-cycle response strobe.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; valid, once raised, stays high with stable payload until that edge
// (unless flush aborts the operation), and ready may change freely.
module ysyx_22041207_muldiv_ctrl
   import ysyx_22041207_muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic        req_word,
   input  logic [63:0] req_a,
   input  logic [63:0] req_b,
   input  logic        flush,
   output logic        resp_valid,
   output logic [63:0] resp_data,
   output logic        busy,
   output logic [63:0] unit_a,
   output logic [63:0] unit_b,
   output logic        mul_valid,
   input  logic        mul_ready,
   input  logic        mul_out_valid,
   input  logic [63:0] mul_res,
   output logic        mul_flush,
   output logic        div_valid,
   output logic        div_sign,
   input  logic        div_ready,
   input  logic        div_out_valid,
   input  logic [63:0] div_q,
   input  logic [63:0] div_r,
   output logic        div_flush,
   output state_t      o_dbg_state
);

   state_t      r_state;
   state_t      w_next;

   logic [63:0] w_a, w_b, w_short_data, w_hit_data;
   logic        w_sign, w_rem, w_is_mul, w_is_div, w_illegal, w_short;
   logic        w_accept, w_hit, w_mul_done, w_div_done;

   logic [63:0] r_a, r_b, r_resp_data;
   logic        r_sign, r_word, r_rem;

   logic        r_c_valid, r_c_sign, r_c_word;
   logic [63:0] r_c_a, r_c_b, r_c_q, r_c_r;

   ysyx_22041207_muldiv_prep u_prep (
      .i_op         (req_op),
      .i_word       (req_word),
      .i_a          (req_a),
      .i_b          (req_b),
      .o_a          (w_a),
      .o_b          (w_b),
      .o_sign       (w_sign),
      .o_rem        (w_rem),
      .o_is_mul     (w_is_mul),
      .o_is_div     (w_is_div),
      .o_illegal    (w_illegal),
      .o_short      (w_short),
      .o_short_data (w_short_data)
   );

   // rst is folded in so nothing is accepted while reset is held.
   assign req_ready  = rst && !flush && (r_state == S_IDLE);
   assign w_accept   = req_valid && req_ready;
   assign w_hit      = r_c_valid && (r_c_a == w_a) && (r_c_b == w_b) &&
                       (r_c_sign == w_sign) && (r_c_word == req_word);
   assign w_hit_data = word_ext(req_word, w_rem ? r_c_r : r_c_q);
   assign w_mul_done = (r_state == S_MUL_WAIT) && mul_out_valid && !flush;
   assign w_div_done = (r_state == S_DIV_WAIT) && div_out_valid && !flush;

   assign busy        = (r_state != S_IDLE);
   assign unit_a      = r_a;
   assign unit_b      = r_b;
   assign div_sign    = r_sign;
   assign resp_data   = r_resp_data;
   assign o_dbg_state = r_state;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   // Next-state and handshake outputs; flush aborts any in-flight operation.
   always_comb begin
      w_next     = r_state;
      mul_valid  = 1'b0;
      div_valid  = 1'b0;
      mul_flush  = 1'b0;
      div_flush  = 1'b0;
      resp_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_illegal)               w_next = S_RESP;
               else if (w_is_mul)           w_next = S_MUL_ISSUE;
               else if (w_short || w_hit)   w_next = S_RESP;
               else                         w_next = S_DIV_ISSUE;
            end
         end
         S_MUL_ISSUE: begin
            if (flush) begin
               w_next    = S_IDLE;
               mul_flush = 1'b1;
            end else begin
               mul_valid = 1'b1;
               if (mul_ready) w_next = S_MUL_WAIT;
            end
         end
         S_MUL_WAIT: begin
            if (flush) begin
               w_next    = S_IDLE;
               mul_flush = 1'b1;
            end else if (mul_out_valid) begin
               w_next = S_RESP;
            end
         end
         S_DIV_ISSUE: begin
            if (flush) begin
               w_next    = S_IDLE;
               div_flush = 1'b1;
            end else begin
               div_valid = 1'b1;
               if (div_ready) w_next = S_DIV_WAIT;
            end
         end
         S_DIV_WAIT: begin
            if (flush) begin
               w_next    = S_IDLE;
               div_flush = 1'b1;
            end else if (div_out_valid) begin
               w_next = S_RESP;
            end
         end
         S_RESP: begin
            w_next     = S_IDLE;
            resp_valid = !flush;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Operand latch and response register; resp_data only changes on entry to RESP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_a         <= 64'd0;
         r_b         <= 64'd0;
         r_sign      <= 1'b0;
         r_word      <= 1'b0;
         r_rem       <= 1'b0;
         r_resp_data <= 64'd0;
      end else begin
         if (w_accept) begin
            r_a    <= w_a;
            r_b    <= w_b;
            r_sign <= w_sign;
            r_word <= req_word;
            r_rem  <= w_rem;
            if (w_illegal)                r_resp_data <= 64'd0;
            else if (w_is_div && w_short) r_resp_data <= w_short_data;
            else if (w_is_div && w_hit)   r_resp_data <= w_hit_data;
         end
         if (w_mul_done) r_resp_data <= word_ext(r_word, mul_res);
         if (w_div_done) r_resp_data <= word_ext(r_word, r_rem ? div_r : div_q);
      end
   end

   // One-entry divider result cache, refreshed on every unflushed completion.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_c_valid <= 1'b0;
         r_c_sign  <= 1'b0;
         r_c_word  <= 1'b0;
         r_c_a     <= 64'd0;
         r_c_b     <= 64'd0;
         r_c_q     <= 64'd0;
         r_c_r     <= 64'd0;
      end else if (w_div_done) begin
         r_c_valid <= 1'b1;
         r_c_sign  <= r_sign;
         r_c_word  <= r_word;
         r_c_a     <= r_a;
         r_c_b     <= r_b;
         r_c_q     <= div_q;
         r_c_r     <= div_r;
      end
   end

endmodule

// File: tb/tb_ysyx_22041207_muldiv_ctrl.sv
// Bench for the mul/div front-end controller with behavioural multiplier and
// divider units and a RISC-V M-extension reference model.
module tb_ysyx_22041207_muldiv_ctrl;
   import ysyx_22041207_muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = 3'd0;
   logic        req_word = 1'b0;
   logic [63:0] req_a = 64'd0;
   logic [63:0] req_b = 64'd0;
   logic        flush = 1'b0;
   logic        resp_valid;
   logic [63:0] resp_data;
   logic        busy;
   logic [63:0] unit_a, unit_b;
   logic        mul_valid, mul_ready, mul_out_valid, mul_flush;
   logic [63:0] mul_res;
   logic        div_valid, div_sign, div_ready, div_out_valid, div_flush;
   logic [63:0] div_q, div_r;
   state_t      dbg_state;

   int n_assert = 0;
   int n_fail   = 0;
   logic [63:0] exp_q[$];

   int mul_lat = 3, div_lat = 3;
   int mul_hs = 0, div_hs = 0, div_vcyc = 0;

   // reference-model copy of the divider cache
   logic        c_valid = 1'b0, c_sign = 1'b0, c_word = 1'b0;
   logic [63:0] c_a = 64'd0, c_b = 64'd0;

   ysyx_22041207_muldiv_ctrl dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_word(req_word), .req_a(req_a), .req_b(req_b),
      .flush(flush), .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy),
      .unit_a(unit_a), .unit_b(unit_b), .mul_valid(mul_valid), .mul_ready(mul_ready),
      .mul_out_valid(mul_out_valid), .mul_res(mul_res), .mul_flush(mul_flush),
      .div_valid(div_valid), .div_sign(div_sign), .div_ready(div_ready),
      .div_out_valid(div_out_valid), .div_q(div_q), .div_r(div_r),
      .div_flush(div_flush), .o_dbg_state(dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   initial forever #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic got, input logic exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] sx32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   // RISC-V M semantics, computed directly from the request.
   function automatic logic [63:0] ref_res(input logic [2:0] op, input logic w,
                                           input logic [63:0] a, input logic [63:0] b);
      logic [31:0] a32, b32, t32;
      int          sa, sb;
      longint      la, lb;
      a32 = a[31:0]; b32 = b[31:0];
      sa = a32; sb = b32; la = a; lb = b;
      case (op)
         3'd0: return w ? sx32(a32 * b32) : a * b;
         3'd1: begin
            if (w) begin
               if (b32 == 32'd0) return {64{1'b1}};
               if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) return sx32(a32);
               t32 = sa / sb;
               return sx32(t32);
            end
            if (b == 64'd0) return {64{1'b1}};
            if (a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) return a;
            return la / lb;
         end
         3'd2: begin
            if (w) return (b32 == 32'd0) ? {64{1'b1}} : sx32(a32 / b32);
            return (b == 64'd0) ? {64{1'b1}} : a / b;
         end
         3'd3: begin
            if (w) begin
               if (b32 == 32'd0) return sx32(a32);
               if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) return 64'd0;
               t32 = sa % sb;
               return sx32(t32);
            end
            if (b == 64'd0) return a;
            if (a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) return 64'd0;
            return la % lb;
         end
         3'd4: begin
            if (w) return (b32 == 32'd0) ? sx32(a32) : sx32(a32 % b32);
            return (b == 64'd0) ? a : a % b;
         end
         default: return 64'd0;
      endcase
   endfunction

   function automatic logic [63:0] prep(input logic [2:0] op, input logic w, input logic [63:0] x);
      if (!w) return x;
      if (op == 3'd1 || op == 3'd3) return sx32(x[31:0]);
      return {32'd0, x[31:0]};
   endfunction

   function automatic logic [127:0] mock_div(input logic s, input logic [63:0] a, input logic [63:0] b);
      logic [63:0] q, r;
      longint      la, lb;
      la = a; lb = b;
      if (b == 64'd0) begin
         q = {64{1'b1}}; r = a;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) begin
         q = a; r = 64'd0;
      end else if (s) begin
         q = la / lb; r = la % lb;
      end else begin
         q = a / b; r = a % b;
      end
      return {q, r};
   endfunction

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 9))
         0: return 64'd0;
         1: return 64'd1;
         2: return {64{1'b1}};
         3: return 64'd7;
         4: return 64'd100;
         5: return 64'h8000_0000_0000_0000;
         6: return 64'h0000_0000_8000_0000;
         7: return 64'h0000_0000_FFFF_FFFF;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   // ---------------- behavioural execution units ----------------
   logic mul_busy, div_busy;
   int   mul_cnt, div_cnt;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mul_busy <= 1'b0; mul_cnt <= 0; mul_out_valid <= 1'b0;
         mul_res <= 64'd0; mul_ready <= 1'b0;
      end else begin
         mul_out_valid <= 1'b0;
         mul_ready     <= ($urandom_range(0, 3) != 0);
         if (mul_flush) mul_busy <= 1'b0;
         else if (mul_busy) begin
            if (mul_cnt <= 1) begin
               mul_busy <= 1'b0; mul_out_valid <= 1'b1;
            end else mul_cnt <= mul_cnt - 1;
         end else if (mul_valid && mul_ready) begin
            mul_busy <= 1'b1; mul_cnt <= mul_lat;
            mul_res  <= unit_a * unit_b;
            mul_hs   <= mul_hs + 1;
         end
      end
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_busy <= 1'b0; div_cnt <= 0; div_out_valid <= 1'b0;
         div_q <= 64'd0; div_r <= 64'd0; div_ready <= 1'b0;
      end else begin
         div_out_valid <= 1'b0;
         div_ready     <= ($urandom_range(0, 3) != 0);
         if (div_valid) div_vcyc <= div_vcyc + 1;
         if (div_flush) div_busy <= 1'b0;
         else if (div_busy) begin
            if (div_cnt <= 1) begin
               div_busy <= 1'b0; div_out_valid <= 1'b1;
            end else div_cnt <= div_cnt - 1;
         end else if (div_valid && div_ready) begin
            div_busy <= 1'b1; div_cnt <= div_lat;
            {div_q, div_r} <= mock_div(div_sign, unit_a, unit_b);
            div_hs <= div_hs + 1;
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (rst) begin
         if (resp_valid) begin
            if (exp_q.size() == 0) chk1("unexpected_resp", resp_valid, 1'b0);
            else chk("resp_data", resp_data, exp_q.pop_front());
         end
         if (mul_valid || div_valid) chk1("valid_exclusive", mul_valid && div_valid, 1'b0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [2:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, output logic ok);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      ok = req_ready;
      if (!ok) begin
         chk1("req_ready_wait", req_ready, 1'b1);
         return;
      end
      req_op = op; req_word = w; req_a = a; req_b = b; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic run(input logic [2:0] op, input logic w, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] exp);
      logic [63:0] pa, pb, minv;
      logic        sg, is_div, use_div, fast, ok;
      int          d0, m0, v0, n;
      pa = prep(op, w, a); pb = prep(op, w, b);
      sg = (op == 3'd1) || (op == 3'd3);
      is_div = (op >= 3'd1) && (op <= 3'd4);
      minv = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
      use_div = is_div && (pb != 64'd0) && !(sg && pa == minv && pb == {64{1'b1}}) &&
                !(c_valid && c_a == pa && c_b == pb && c_sign == sg && c_word == w);
      fast = (op > 3'd4) || (is_div && !use_div);
      d0 = div_hs; m0 = mul_hs; v0 = div_vcyc;
      exp_q.push_back(exp);
      send(op, w, a, b, ok);
      if (!ok) begin
         void'(exp_q.pop_back());
         return;
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!resp_valid && n < 300);
      chk1("resp_seen", resp_valid, 1'b1);
      if (!resp_valid) begin
         exp_q.delete();
         return;
      end
      if (fast) begin
         chk("fast_latency", 64'(n), 64'd1);
         chk("fast_no_div_valid", 64'(div_vcyc - v0), 64'd0);
      end
      chk("div_handshakes", 64'(div_hs - d0), {63'd0, use_div});
      chk("mul_handshakes", 64'(mul_hs - m0), {63'd0, op == 3'd0});
      @(negedge clk);
      chk1("resp_one_cycle", resp_valid, 1'b0);
      if (use_div) begin
         c_valid = 1'b1; c_a = pa; c_b = pb; c_sign = sg; c_word = w;
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ctl"}, {56'd0, resp_valid, mul_valid, div_valid, mul_flush,
                          div_flush, busy, div_sign, req_ready}, 64'd0);
      chk({tag, "_resp_data"}, resp_data, 64'd0);
      chk({tag, "_unit_a"}, unit_a, 64'd0);
      chk({tag, "_unit_b"}, unit_b, 64'd0);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic        ok;
      logic [2:0]  op;
      logic        w;
      logic [63:0] a, b;
      int          n, d0, m0;

      repeat (2) @(negedge clk);
      chk_reset_outputs("reset_init");
      rst = 1'b1;
      #1;
      chk1("ready_after_reset", req_ready, 1'b1);

      // multiply, fixed unit latency
      mul_lat = 5;
      run(3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA);
      // word multiply: operands zero-extended, result sign-extended
      run(3'd0, 1'b1, 64'h1_0000_0003, 64'h0000_0000_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA);

      // divide by zero shortcuts
      run(3'd1, 1'b0, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
      run(3'd4, 1'b0, 64'd7, 64'd0, 64'd7);

      // word signed overflow shortcuts
      run(3'd1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
      run(3'd3, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0);

      // divider then cache hit on the companion op
      div_lat = 4;
      run(3'd2, 1'b0, 64'd100, 64'd7, 64'd14);
      run(3'd4, 1'b0, 64'd100, 64'd7, 64'd2);

      // illegal op answers zero
      run(3'd5, 1'b0, 64'd5, 64'd6, 64'd0);

      // flush together with a request accepts nothing
      @(negedge clk);
      flush = 1'b1; req_valid = 1'b1; req_op = 3'd0; req_a = 64'd9; req_b = 64'd9;
      #1;
      chk1("flush_blocks_ready", req_ready, 1'b0);
      @(posedge clk);
      #1;
      chk1("flush_nothing_accepted", busy, 1'b0);
      req_valid = 1'b0; flush = 1'b0;

      // flush two cycles into DIV_WAIT
      div_lat = 10;
      d0 = div_hs;
      send(3'd1, 1'b0, 64'd1000, 64'd13, ok);
      n = 0;
      while (div_hs == d0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("flush_div_started", 64'(div_hs - d0), 64'd1);
      @(negedge clk);
      flush = 1'b1;
      #1;
      chk1("flush_div_flush_pulse", div_flush, 1'b1);
      chk1("flush_div_valid_low", div_valid, 1'b0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush_idle_next", {61'd0, dbg_state}, {61'd0, S_IDLE});
      chk1("flush_pulse_ended", div_flush, 1'b0);
      chk1("flush_not_busy", busy, 1'b0);
      repeat (15) @(negedge clk);
      div_lat = 3;
      run(3'd3, 1'b0, 64'd1000, 64'd13, 64'd12);

      // reset in the middle of a multiply
      mul_lat = 20;
      m0 = mul_hs;
      send(3'd0, 1'b0, 64'd5, 64'd9, ok);
      n = 0;
      while (mul_hs == m0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_reset_outputs("reset_mid_mul");
      c_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      mul_lat = 3;
      run(3'd0, 1'b0, 64'd5, 64'd9, 64'd45);
      run(3'd4, 1'b0, 64'd100, 64'd7, 64'd2);

      // random mix against the reference model
      a = 64'd0; b = 64'd0;
      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(0, 6));
         w  = 1'($urandom_range(0, 1));
         if (i == 0 || $urandom_range(0, 3) != 0) begin
            a = pick();
            b = pick();
         end
         mul_lat = $urandom_range(1, 6);
         div_lat = $urandom_range(1, 6);
         run(op, w, a, b, ref_res(op, w, a, b));
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
